// File: rtl/hh_spike_encoder.sv
// Spike encoder for the linear Hodgkin-Huxley neuron: threshold/hysteresis/refractory
// detection, inter-spike-interval FIFO (first-word fall-through) and windowed firing rate.
module hh_spike_encoder #(
   parameter int ISI_WIDTH      = 8,
   parameter int FIFO_DEPTH     = 4,
   parameter int WINDOW_SAMPLES = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [7:0]           v_in,
   input  logic                 v_valid,
   input  logic [7:0]           threshold,
   input  logic [7:0]           hyst,
   input  logic [3:0]           refractory,
   output logic                 spike,
   output logic [7:0]           rate,
   output logic                 rate_valid,
   output logic [ISI_WIDTH-1:0] isi_data,
   output logic                 isi_valid,
   input  logic                 isi_ready,
   output logic                 overflow
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int WIN_W = $clog2(WINDOW_SAMPLES + 1);
   localparam logic [ISI_WIDTH-1:0] ISI_MAX = '1;

   localparam logic [1:0] ST_BELOW   = 2'd0;
   localparam logic [1:0] ST_REFRACT = 2'd1;
   localparam logic [1:0] ST_ABOVE   = 2'd2;

   function automatic logic [7:0] sat0_sub(input logic [7:0] a, input logic [7:0] b);
      return (a > b) ? (a - b) : 8'd0;
   endfunction

   function automatic logic [ISI_WIDTH-1:0] isi_sat_inc(input logic [ISI_WIDTH-1:0] c);
      return (c == ISI_MAX) ? c : c + ISI_WIDTH'(1);
   endfunction

   function automatic logic [7:0] cnt8_sat_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   logic [1:0]           state_q, state_d;
   logic [3:0]           rcnt_q, rcnt_d;
   logic                 spike_q, spike_d;
   logic [ISI_WIDTH-1:0] isi_cnt_q, isi_cnt_d;
   logic                 have_prev_q, have_prev_d;
   logic [ISI_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wptr_q, wptr_d;
   logic [PTR_W-1:0]     rptr_q, rptr_d;
   logic [CNT_W-1:0]     fcnt_q, fcnt_d;
   logic                 overflow_q, overflow_d;
   logic [WIN_W-1:0]     wcnt_q, wcnt_d;
   logic [7:0]           scnt_q, scnt_d;
   logic [7:0]           rate_q, rate_d;
   logic                 rate_valid_q, rate_valid_d;

   logic [7:0]           rearm;
   logic                 spike_det;
   logic                 push;
   logic [ISI_WIDTH-1:0] push_val;
   logic                 fifo_empty, fifo_full, pop, wr_en;
   logic [7:0]           scnt_inc;

   assign rearm = sat0_sub(threshold, hyst);

   // Detector: only BELOW evaluates the threshold; REFRACT ignores samples entirely.
   always_comb begin
      state_d   = state_q;
      rcnt_d    = rcnt_q;
      spike_det = 1'b0;
      if (v_valid) begin
         case (state_q)
            ST_BELOW: begin
               if (v_in >= threshold) begin
                  spike_det = 1'b1;
                  if (refractory != 4'd0) begin
                     state_d = ST_REFRACT;
                     rcnt_d  = refractory;
                  end else begin
                     state_d = ST_ABOVE;
                  end
               end
            end
            ST_REFRACT: begin
               rcnt_d = rcnt_q - 4'd1;
               if (rcnt_q <= 4'd1) begin
                  rcnt_d  = 4'd0;
                  state_d = ST_ABOVE;
               end
            end
            ST_ABOVE: begin
               if (v_in < rearm) state_d = ST_BELOW;
            end
            default: state_d = ST_BELOW;
         endcase
      end
   end

   always_comb begin
      spike_d     = v_valid && spike_det;
      isi_cnt_d   = isi_cnt_q;
      have_prev_d = have_prev_q;
      push        = 1'b0;
      push_val    = isi_sat_inc(isi_cnt_q);
      if (v_valid) begin
         if (spike_det) begin
            isi_cnt_d   = '0;
            have_prev_d = 1'b1;
            push        = have_prev_q;
         end else begin
            isi_cnt_d = isi_sat_inc(isi_cnt_q);
         end
      end
   end

   // A pop frees the slot in the same cycle, so push-at-full with pop is lossless.
   assign fifo_empty = (fcnt_q == '0);
   assign fifo_full  = (fcnt_q == CNT_W'(FIFO_DEPTH));
   assign pop        = !fifo_empty && isi_ready;
   assign wr_en      = push && (!fifo_full || pop);

   always_comb begin
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      fcnt_d     = fcnt_q;
      overflow_d = overflow_q;
      if (wr_en) wptr_d = wptr_q + PTR_W'(1);
      if (pop)   rptr_d = rptr_q + PTR_W'(1);
      if (wr_en && !pop)      fcnt_d = fcnt_q + CNT_W'(1);
      else if (pop && !wr_en) fcnt_d = fcnt_q - CNT_W'(1);
      if (push && !wr_en) overflow_d = 1'b1;
   end

   always_comb begin
      wcnt_d       = wcnt_q;
      scnt_d       = scnt_q;
      rate_d       = rate_q;
      rate_valid_d = 1'b0;
      scnt_inc     = spike_det ? cnt8_sat_inc(scnt_q) : scnt_q;
      if (v_valid) begin
         if (wcnt_q == WIN_W'(WINDOW_SAMPLES - 1)) begin
            rate_d       = scnt_inc;
            rate_valid_d = 1'b1;
            wcnt_d       = '0;
            scnt_d       = 8'd0;
         end else begin
            wcnt_d = wcnt_q + WIN_W'(1);
            scnt_d = scnt_inc;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_BELOW;
         rcnt_q       <= 4'd0;
         spike_q      <= 1'b0;
         isi_cnt_q    <= '0;
         have_prev_q  <= 1'b0;
         wptr_q       <= '0;
         rptr_q       <= '0;
         fcnt_q       <= '0;
         overflow_q   <= 1'b0;
         wcnt_q       <= '0;
         scnt_q       <= 8'd0;
         rate_q       <= 8'd0;
         rate_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rcnt_q       <= rcnt_d;
         spike_q      <= spike_d;
         isi_cnt_q    <= isi_cnt_d;
         have_prev_q  <= have_prev_d;
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         fcnt_q       <= fcnt_d;
         overflow_q   <= overflow_d;
         wcnt_q       <= wcnt_d;
         scnt_q       <= scnt_d;
         rate_q       <= rate_d;
         rate_valid_q <= rate_valid_d;
      end
   end

   // Storage needs no reset: the occupancy count gates what is visible.
   always_ff @(posedge clock) begin
      if (!reset && wr_en) mem_q[wptr_q] <= push_val;
   end

   assign spike      = spike_q;
   assign rate       = rate_q;
   assign rate_valid = rate_valid_q;
   assign isi_valid  = !fifo_empty;
   assign isi_data   = fifo_empty ? '0 : mem_q[rptr_q];
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_hh_spike_encoder.sv
// Self-checking bench for hh_spike_encoder: directed scenarios plus randomized traffic
// compared against a sample-level behavioural model.
module tb_hh_spike_encoder;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] v_in;
   logic       v_valid;
   logic [7:0] threshold;
   logic [7:0] hyst;
   logic [3:0] refractory;
   logic       spike;
   logic [7:0] rate;
   logic       rate_valid;
   logic [7:0] isi_data;
   logic       isi_valid;
   logic       isi_ready;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   // Model state, expressed in terms of samples and spike indices.
   bit m_armed;
   int m_ignore;
   bit m_have_prev;
   int m_idx;
   int m_last;
   int m_q[$];
   bit m_ovf;
   int m_win_pos;
   int m_win_spk;
   int m_rate;
   bit m_rv;
   bit m_spike;

   always #5 clock = ~clock;

   hh_spike_encoder #(
      .ISI_WIDTH(8),
      .FIFO_DEPTH(4),
      .WINDOW_SAMPLES(16)
   ) dut (
      .clock(clock),
      .reset(reset),
      .v_in(v_in),
      .v_valid(v_valid),
      .threshold(threshold),
      .hyst(hyst),
      .refractory(refractory),
      .spike(spike),
      .rate(rate),
      .rate_valid(rate_valid),
      .isi_data(isi_data),
      .isi_valid(isi_valid),
      .isi_ready(isi_ready),
      .overflow(overflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_armed = 1; m_ignore = 0; m_have_prev = 0; m_idx = 0; m_last = 0;
      m_q.delete(); m_ovf = 0; m_win_pos = 0; m_win_spk = 0;
      m_rate = 0; m_rv = 0; m_spike = 0;
   endtask

   task automatic model_step(input int v, input bit vv, input bit rdy);
      bit det;
      int thr, rearm, d;
      det = 0;
      m_rv = 0;
      m_spike = 0;
      thr = int'(threshold);
      rearm = (thr > int'(hyst)) ? thr - int'(hyst) : 0;
      if (rdy && m_q.size() > 0) void'(m_q.pop_front());
      if (vv) begin
         if (m_armed) begin
            if (v >= thr) begin
               det = 1; m_armed = 0; m_ignore = int'(refractory);
            end
         end else if (m_ignore > 0) begin
            m_ignore--;
         end else if (v < rearm) begin
            m_armed = 1;
         end
         if (det) begin
            if (m_have_prev) begin
               d = m_idx - m_last;
               if (d > 255) d = 255;
               if (m_q.size() < 4) m_q.push_back(d);
               else m_ovf = 1;
            end
            m_last = m_idx;
            m_have_prev = 1;
            if (m_win_spk < 255) m_win_spk++;
         end
         m_idx++;
         m_win_pos++;
         if (m_win_pos == 16) begin
            m_rate = m_win_spk; m_rv = 1; m_win_pos = 0; m_win_spk = 0;
         end
         m_spike = det;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".spike"},      spike,      m_spike);
      check({tag, ".rate"},       rate,       m_rate);
      check({tag, ".rate_valid"}, rate_valid, m_rv);
      check({tag, ".isi_valid"},  isi_valid,  m_q.size() > 0);
      check({tag, ".isi_data"},   isi_data,   (m_q.size() > 0) ? m_q[0] : 0);
      check({tag, ".overflow"},   overflow,   m_ovf);
   endtask

   task automatic step(input string tag, input int v, input bit vv, input bit rdy);
      v_in = v[7:0]; v_valid = vv; isi_ready = rdy;
      model_step(v, vv, rdy);
      @(posedge clock);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      for (int i = 0; i < n; i++) begin
         v_in = 8'($urandom); v_valid = 1'($urandom); isi_ready = 1'($urandom);
         threshold = 8'($urandom); hyst = 8'($urandom); refractory = 4'($urandom);
         @(posedge clock);
         #1;
         model_reset();
         check_all("reset");
      end
      reset = 1'b0;
   endtask

   task automatic lows(input string tag, input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(tag, 10, 1, rdy);
   endtask

   task automatic cfg(input int thr, input int hy, input int rf);
      threshold = thr[7:0]; hyst = hy[7:0]; refractory = rf[3:0];
   endtask

   initial begin
      bit [6:0] pat;
      reset = 1'b1; v_in = '0; v_valid = 0; isi_ready = 0;
      threshold = '0; hyst = '0; refractory = '0;
      model_reset();

      // Reset values, then first spike pushes nothing.
      do_reset(2);
      check("reset_spike", spike, 0);
      check("reset_isi_valid", isi_valid, 0);
      cfg(100, 10, 2);
      step("first", 200, 1, 0);
      check("first_spike", spike, 1);
      check("first_no_isi", isi_valid, 0);

      // Hysteresis and refractory.
      do_reset(1);
      cfg(100, 10, 2);
      begin
         int samples[7] = '{50, 100, 120, 90, 95, 80, 100};
         for (int i = 0; i < 7; i++) begin
            step("hyst", samples[i], 1, 0);
            pat[i] = spike;
         end
      end
      check("hyst_pattern", pat, 7'b1000010);

      // ISI measurement and FWFT drain.
      do_reset(1);
      cfg(100, 0, 0);
      step("isi", 200, 1, 0);
      lows("isi", 4, 0);
      step("isi", 200, 1, 0);
      lows("isi", 6, 0);
      step("isi", 200, 1, 0);
      check("isi_head5", isi_data, 5);
      step("isi_pop", 0, 0, 1);
      check("isi_head7", isi_data, 7);
      step("isi_pop", 0, 0, 1);
      check("isi_empty", isi_valid, 0);

      // Overflow with isi_ready low: ISIs 2..6, the 6 dropped.
      do_reset(1);
      cfg(100, 0, 0);
      step("ovf", 200, 1, 0);
      for (int g = 2; g <= 6; g++) begin
         lows("ovf", g - 1, 0);
         step("ovf", 200, 1, 0);
      end
      check("ovf_set", overflow, 1);
      for (int k = 0; k < 4; k++) begin
         check("ovf_drain", isi_data, 2 + k);
         step("ovf_drain", 0, 0, 1);
      end
      check("ovf_drained", isi_valid, 0);
      check("ovf_sticky", overflow, 1);

      // Push and pop together while full.
      do_reset(1);
      cfg(100, 0, 0);
      step("full", 200, 1, 0);
      for (int k = 0; k < 4; k++) begin
         lows("full", 1, 0);
         step("full", 200, 1, 0);
      end
      lows("full", 1, 0);
      step("full_pushpop", 200, 1, 1);
      check("full_no_ovf", overflow, 0);
      check("full_head", isi_data, 2);

      // ISI counter saturation.
      do_reset(1);
      cfg(100, 0, 0);
      step("sat", 200, 1, 0);
      lows("sat", 300, 0);
      step("sat", 200, 1, 0);
      check("sat_isi", isi_data, 255);

      // Rate window with invalid gaps.
      do_reset(1);
      cfg(100, 0, 0);
      step("rate", 200, 1, 0);
      lows("rate", 3, 0);
      for (int i = 0; i < 3; i++) step("rate_gap", 200, 0, 0);
      step("rate", 200, 1, 0);
      lows("rate", 10, 0);
      step("rate", 200, 1, 0);
      check("rate_pulse", rate_valid, 1);
      check("rate_value", rate, 3);
      step("rate", 10, 1, 0);
      check("rate_pulse_end", rate_valid, 0);
      check("rate_hold", rate, 3);

      // Reset mid-operation while refractory with 2 entries queued.
      do_reset(1);
      cfg(100, 0, 0);
      step("mid", 200, 1, 0);
      lows("mid", 1, 0);
      step("mid", 200, 1, 0);
      refractory = 4'd5;
      lows("mid", 1, 0);
      step("mid", 200, 1, 0);
      check("mid_two", isi_valid, 1);
      do_reset(1);
      check("mid_empty", isi_valid, 0);
      cfg(100, 0, 0);
      step("mid_after", 200, 1, 0);
      check("mid_first_spike", spike, 1);
      check("mid_no_push", isi_valid, 0);

      // Randomized traffic.
      do_reset(1);
      cfg(100, 10, 2);
      for (int n = 0; n < 3000; n++) begin
         if (n % 60 == 0) begin
            cfg(int'($urandom_range(1, 255)), int'($urandom_range(0, 60)),
                int'($urandom_range(0, 5)));
            if ($urandom_range(0, 9) == 0) hyst = threshold;
         end
         if ($urandom_range(0, 199) == 0) do_reset(1);
         else step("rand", int'($urandom_range(0, 255)), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 9) < 3);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hh_spike_encoder.md
Name: hh_spike_encoder

Overview:
- Downstream stage of the linear Hodgkin-Huxley neuron.
- Samples the neuron's 8-bit membrane potential, detects threshold crossings with hysteresis and a refractory period, and emits one-cycle spike pulses.
- Measures inter-spike intervals (ISI) into a small FWFT FIFO with a valid/ready read port.
- Reports spikes-per-window as a firing-rate value.

Parameters:
ISI_WIDTH, 8, width of ISI values and ISI counter (saturating)
FIFO_DEPTH, 4, ISI FIFO entries (power of 2)
WINDOW_SAMPLES, 16, v_valid samples per rate window

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
v_in  in  8  membrane potential, unsigned, from neuron data_out
v_valid  in  1  v_in holds a new sample this cycle
threshold  in  8  spike threshold, unsigned, used live per sample
hyst  in  8  hysteresis; rearm level = sat0(threshold - hyst)
refractory  in  4  samples ignored after a spike
spike  out  1  one-cycle pulse per detected spike
rate  out  8  spike count of last completed window, saturating at 255
rate_valid  out  1  one-cycle pulse when rate updates
isi_data  out  ISI_WIDTH  FIFO head ISI, in samples
isi_valid  out  1  FIFO not empty
isi_ready  in  1  consumer accepts head
overflow  out  1  sticky: ISI dropped because FIFO was full

Behaviour:
- Reset: all outputs 0, state BELOW, FIFO empty, all counters 0, have_prev_spike=0. Reset overrides any in-flight operation.
- When v_valid=0: detector, ISI and window state hold; only a FIFO pop may occur.
- State machine (advances only on v_valid):
  - BELOW: v_in >= threshold -> spike. Next state REFRACT (refractory>0, load rcnt=refractory) or ABOVE (refractory=0).
  - REFRACT: each sample decrements rcnt, with no threshold/rearm evaluation. The sample taking rcnt to 0 moves to ABOVE, so exactly `refractory` samples are ignored.
  - ABOVE: v_in < sat0(threshold - hyst) -> BELOW. Equality does not rearm.
  - If hyst >= threshold, the rearm level is 0 and ABOVE never exits; this is intended.
- Spike latency: spike goes high the cycle after the detecting sample's cycle (registered) for exactly 1 cycle. Back-to-back spikes are impossible: at least one rearm sample is required.
- ISI counter:
  - Cleared to 0 on a spike sample; otherwise +1 per v_valid sample, saturating at 2^ISI_WIDTH-1.
  - At a spike sample, pushed ISI = sat(isi_cnt+1), the sample-index distance between spikes.
  - No push for the first spike after reset; that spike sets have_prev_spike.
- FIFO (FWFT):
  - isi_valid = not empty; isi_data = head.
  - Pop when isi_valid && isi_ready.
  - A push lands on the same edge that raises spike, so isi_valid/isi_data reflect it in the same cycle spike is high.
  - Push while full with a simultaneous pop: both occur, count unchanged, order preserved.
  - Push while full without a pop: new value dropped; overflow set, cleared only by reset.
  - Pop while empty: impossible (isi_valid=0).
  - Pointers wrap modulo FIFO_DEPTH.
- Rate window:
  - wcnt counts v_valid samples; scnt counts spike samples in the window, saturating at 255.
  - On the WINDOW_SAMPLES-th sample: rate <= scnt (including a spike on that same sample), rate_valid pulses with the same 1-cycle latency as spike, and wcnt/scnt restart at 0.
  - rate holds between updates.

Test Plan:
- Reset: assert reset 2 cycles with random inputs -> spike, rate, rate_valid, isi_valid, overflow, isi_data all 0. The first sample of 200 with threshold=100 gives spike; isi_valid stays 0.
- Hysteresis/refractory: threshold=100, hyst=10, refractory=2; samples 50,100,120,90,95,80,100 -> spike after sample 2 and after sample 7 only. 120 and 90 are ignored; 95 does not rearm; 80 rearms.
- ISI: refractory=0, hyst=0; spikes at sample indices 0,5,12 (low samples between) -> FIFO holds 5 then 7. isi_ready=1 pops 5 then 7, then isi_valid=0.
- Overflow: isi_ready=0; 6 spikes -> 5 ISIs, 4 stored, overflow=1 after the 6th spike. Drain returns the first 4 ISIs in order; overflow stays 1. A simultaneous push+pop at full keeps 4 entries and does not set overflow.
- Rate: WINDOW_SAMPLES=16, 3 spikes in the window (one on sample 16) -> rate=3 with a 1-cycle rate_valid after sample 16. Gaps with v_valid=0 inside the window do not count.
- Reset mid-operation: reset while in REFRACT with 2 FIFO entries -> next cycle FIFO empty and state BELOW. The next spike is treated as the first: no ISI push.
